// File: rtl/data_memory.sv
// Word-addressed data memory for the multi-cycle datapath.
// Synchronous write, combinational gated read, async clear.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_signal,
  input  logic              read_signal,
  output logic [DATA_W-1:0] data_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  // Full address is compared so out-of-range never aliases.
  assign in_range = (addr < DEPTH_A);
  assign idx      = addr[IDX_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_signal && in_range) begin
      mem[idx] <= data_in;
    end
  end

  always_comb begin
    data_out = '0;
    if (!reset && read_signal && in_range) begin
      data_out = mem[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
// Inputs change after negedge; outputs sampled #1 later.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        write_signal;
  logic        read_signal;
  logic [31:0] data_out;

  int n_pass;
  int n_total;

  data_memory dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .data_in      (data_in),
    .write_signal (write_signal),
    .read_signal  (read_signal),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr         = a;
    data_in      = d;
    write_signal = 1'b1;
    read_signal  = 1'b0;
    @(posedge clk);
    #1;
    write_signal = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] exp,
                    input string tag);
    addr        = a;
    read_signal = 1'b1;
    #1;
    check(tag, data_out, exp);
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    reset        = 1'b1;
    addr         = '0;
    data_in      = '0;
    write_signal = 1'b0;
    read_signal  = 1'b1;
    #12;
    check("rst_hold_out", data_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(32'd0,   32'h0, "rst_a0");
    rd(32'd10,  32'h0, "rst_a10");
    rd(32'd255, 32'h0, "rst_a255");

    wr(32'd10, 32'd123);
    rd(32'd10, 32'd123, "wr_rd_a10");

    read_signal = 1'b0;
    #1;
    check("gate_off", data_out, 32'h0);
    read_signal = 1'b1;
    #1;
    check("gate_on", data_out, 32'd123);

    wr(32'd255, 32'hFFFF_FFFF);
    wr(32'd0,   32'hA5A5_A5A5);
    rd(32'd255, 32'hFFFF_FFFF, "bnd_a255");
    rd(32'd0,   32'hA5A5_A5A5, "bnd_a0");
    wr(32'd256, 32'h1);
    rd(32'd256, 32'h0, "oor_a256");
    rd(32'd0,   32'hA5A5_A5A5, "oor_noalias");
    rd(32'h8000_000A, 32'h0, "oor_high");

    wr(32'd20, 32'd7);
    @(negedge clk);
    addr         = 32'd20;
    data_in      = 32'd9;
    write_signal = 1'b1;
    read_signal  = 1'b1;
    #1;
    check("raw_before", data_out, 32'd7);
    @(posedge clk);
    #1;
    check("raw_after", data_out, 32'd9);
    write_signal = 1'b0;

    @(negedge clk);
    addr         = 32'd40;
    data_in      = 32'h11;
    write_signal = 1'b1;
    read_signal  = 1'b0;
    #1;
    check("wr_only_out0", data_out, 32'h0);
    @(posedge clk);
    #1;
    write_signal = 1'b0;
    rd(32'd40,  32'h11,        "diff_a40");
    rd(32'd255, 32'hFFFF_FFFF, "diff_a255");

    wr(32'd10, 32'd55);
    rd(32'd10, 32'd55, "pre_rst_a10");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", data_out, 32'h0);
    reset = 1'b0;
    #1;
    check("async_clr_a10", data_out, 32'h0);
    rd(32'd255, 32'h0, "async_clr_a255");
    rd(32'd40,  32'h0, "async_clr_a40");

    @(negedge clk);
    addr         = 32'd30;
    data_in      = 32'd77;
    write_signal = 1'b1;
    read_signal  = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    write_signal = 1'b0;
    reset        = 1'b0;
    rd(32'd30, 32'h0, "rst_edge_wr_lost");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
